// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with bounded memory waits.
// Strobes decode from registered state; sw alone follows dmem_ack combinationally.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        lb,
    output logic        sw,
    output logic        lui_control,
    output logic        jmp,
    output logic        alu_wb,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        busy,
    output logic        trap,
    output logic [2:0]  state
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_LOAD, C_STORE, C_LUI, C_JAL, C_ALU, C_ILL
    } cls_t;

    state_t        state_q;
    cls_t          cls_q;
    cls_t          cls_d;
    logic [31:0]   ir_q;
    logic [CW-1:0] cnt_q;
    logic          timeout_hit;
    logic          in_wb;
    logic          rd_nz;
    logic          unused_ir;

    always_comb begin
        cls_d = C_ILL;
        case (ir_q[6:0])
            7'b0000011:             cls_d = C_LOAD;
            7'b0100011:             cls_d = C_STORE;
            7'b0110111:             cls_d = C_LUI;
            7'b1101111:             cls_d = C_JAL;
            7'b0110011, 7'b0010011: cls_d = C_ALU;
            default:                cls_d = C_ILL;
        endcase
    end

    // Last waiting cycle: an ack here still wins over the trap.
    assign timeout_hit = (cnt_q == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cls_q   <= C_LOAD;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_FETCH;
                        cnt_q   <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q    <= instr;
                        state_q <= S_DECODE;
                    end else if (timeout_hit) begin
                        state_q <= S_TRAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    cls_q   <= cls_d;
                    state_q <= (cls_d == C_ILL) ? S_TRAP : S_EXEC;
                end
                S_EXEC: begin
                    cnt_q   <= '0;
                    state_q <= (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        state_q <= S_WB;
                    end else if (timeout_hit) begin
                        state_q <= S_TRAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    if (run) begin
                        state_q <= S_FETCH;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_TRAP;
            endcase
        end
    end

    assign in_wb = (state_q == S_WB);
    assign rd_nz = |ir_q[11:7];

    assign imem_req    = (state_q == S_FETCH);
    assign dmem_req    = (state_q == S_MEM);
    assign dmem_we     = (state_q == S_MEM) && (cls_q == C_STORE);
    assign sw          = (state_q == S_MEM) && (cls_q == C_STORE) && dmem_ack;
    assign lb          = in_wb && rd_nz && (cls_q == C_LOAD);
    assign lui_control = in_wb && rd_nz && (cls_q == C_LUI);
    assign jmp         = in_wb && rd_nz && (cls_q == C_JAL);
    assign alu_wb      = in_wb && rd_nz && (cls_q == C_ALU);
    assign pc_en       = in_wb;
    assign pc_sel      = in_wb && (cls_q == C_JAL);
    assign busy        = (state_q != S_IDLE);
    assign trap        = (state_q == S_TRAP);
    assign state       = state_q;

    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign rd  = ir_q[11:7];

    assign unused_ir = ^{ir_q[31:25], ir_q[14:12]};
endmodule
